accel_sequencer: RTL and testbench
==================================

ACCEL_SEQUENCER -- requirements
Module: accel_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, data-memory address width.
REQ-002 Parameter DATA_W, default 16, data word and engine operand width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 encr_en / decr_en / fft_en  input  1 each  operation requests from the control decoder, sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  first word address, latched at start.
REQ-007 length  input  8  word count, latched at start.
REQ-008 mem_rd  output  1  read strobe to data memory.
REQ-009 mem_wr  output  1  write strobe to data memory.
REQ-010 mem_addr  output  ADDR_W  address for mem_rd or mem_wr.
REQ-011 mem_wdata  output  DATA_W  write data.
REQ-012 mem_rdata  input  DATA_W  read data, valid exactly one cycle after mem_rd.
REQ-013 eng_sel  output  2  engine select: 01 encr, 10 decr, 11 fft, 00 none.
REQ-014 eng_in_valid / eng_in_ready  output / input  1  operand handshake to engine.
REQ-015 eng_in_data  output  DATA_W  operand.
REQ-016 eng_out_valid  input  1  engine result valid.
REQ-017 eng_out_data  input  DATA_W  engine result.
REQ-018 busy  output  1  high in every state except IDLE; core stalls its PC while high.
REQ-019 done  output  1  one-cycle pulse at completion.

Function
REQ-020 States SHALL be IDLE, RD, RWAIT, SEND, EWAIT, WR, FIN; one-hot or binary encoding is free.
REQ-021 IDLE: any of encr_en/decr_en/fft_en high -> latch op, base_addr into addr counter, length into remaining counter; go RD if length!=0, else FIN.
REQ-022 Simultaneous requests: priority encr_en > decr_en > fft_en; lower ones ignored, not queued.
REQ-023 RD: mem_rd=1, mem_addr=addr for exactly one cycle -> RWAIT.
REQ-024 RWAIT: capture mem_rdata into operand register -> SEND.
REQ-025 SEND: eng_in_valid=1, eng_in_data=operand held stable; transfer when eng_in_valid & eng_in_ready -> EWAIT; waits indefinitely otherwise.
REQ-026 EWAIT: on eng_out_valid capture eng_out_data -> WR; eng_out_valid outside EWAIT ignored.
REQ-027 WR: mem_wr=1, mem_addr=addr, mem_wdata=captured result for one cycle; addr+1 (wraps modulo 2^ADDR_W), remaining-1; remaining now 0 -> FIN, else RD.
REQ-028 FIN: done=1 for one cycle, eng_sel cleared -> IDLE; new request accepted next cycle earliest.
REQ-029 eng_sel SHALL equal latched op from start through WR; 00 in IDLE and FIN.
REQ-030 mem_rd and mem_wr SHALL never be high in the same cycle.
REQ-031 Minimum per-word latency with eng_in_ready=1 and result one cycle after transfer: 5 cycles (RD,RWAIT,SEND,EWAIT,WR).
REQ-032 Request inputs SHALL be ignored while busy.

Reset
REQ-033 rst_n low SHALL immediately force IDLE and drive busy, done, mem_rd, mem_wr, eng_in_valid to 0, eng_sel to 00, mem_addr, mem_wdata, eng_in_data and counters to 0.
REQ-034 Reset mid-operation SHALL abandon the transfer; no write issued after deassertion until a new request.

Verification
REQ-035 encr_en, base_addr=0x10, length=2, engine returns operand^0xFFFF -> reads 0x10,0x11, writes inverted data to same addresses, done one cycle after final write, busy high 11 cycles.
REQ-036 fft_en and encr_en same cycle, length=1 -> eng_sel=01 throughout, single read/write.
REQ-037 length=0 with decr_en -> busy high 1 cycle (FIN), done pulse, no mem_rd/mem_wr.
REQ-038 eng_in_ready held low 4 cycles in SEND -> eng_in_valid and eng_in_data stable 5 cycles, single transfer.
REQ-039 base_addr=0xFF, length=2 -> second access at 0x00.
REQ-040 rst_n low during EWAIT, late eng_out_valid -> no mem_wr, outputs at reset values, busy=0.

Source files
------------

// File: rtl/accel_sequencer.sv
// Accelerator sequencer: streams words from data memory through a selected
// engine (encr/decr/fft) and writes each result back to the same address.
module accel_sequencer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              encr_en,
  input  logic              decr_en,
  input  logic              fft_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        length,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        eng_sel,
  output logic              eng_in_valid,
  input  logic              eng_in_ready,
  output logic [DATA_W-1:0] eng_in_data,
  input  logic              eng_out_valid,
  input  logic [DATA_W-1:0] eng_out_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LEN_W = 8;

  typedef enum logic [2:0] {IDLE, RD, RWAIT, SEND, EWAIT, WR, FIN} state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  addr, addr_n;
  logic [LEN_W-1:0]   remaining, remaining_n;
  logic [1:0]         op, op_n;
  logic [DATA_W-1:0]  operand, operand_n;
  logic [DATA_W-1:0]  result, result_n;

  // Next-state and datapath update
  always_comb begin
    state_n     = state;
    addr_n      = addr;
    remaining_n = remaining;
    op_n        = op;
    operand_n   = operand;
    result_n    = result;
    unique case (state)
      IDLE: begin
        if (encr_en || decr_en || fft_en) begin
          op_n        = encr_en ? 2'b01 : (decr_en ? 2'b10 : 2'b11);
          addr_n      = base_addr;
          remaining_n = length;
          state_n     = (length != '0) ? RD : FIN;
        end
      end
      RD:    state_n = RWAIT;
      RWAIT: begin
        operand_n = mem_rdata;
        state_n   = SEND;
      end
      SEND:  if (eng_in_valid && eng_in_ready) state_n = EWAIT;
      EWAIT: begin
        if (eng_out_valid) begin
          result_n = eng_out_data;
          state_n  = WR;
        end
      end
      WR: begin
        addr_n      = addr + ADDR_W'(1);
        remaining_n = remaining - LEN_W'(1);
        state_n     = (remaining_n == '0) ? FIN : RD;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and outputs; outputs are decoded from the next state so
  // they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr         <= '0;
      remaining    <= '0;
      op           <= '0;
      operand      <= '0;
      result       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      eng_in_valid <= 1'b0;
      eng_sel      <= 2'b00;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      eng_in_data  <= '0;
    end else begin
      state        <= state_n;
      addr         <= addr_n;
      remaining    <= remaining_n;
      op           <= op_n;
      operand      <= operand_n;
      result       <= result_n;
      busy         <= (state_n != IDLE);
      done         <= (state_n == FIN);
      mem_rd       <= (state_n == RD);
      mem_wr       <= (state_n == WR);
      eng_in_valid <= (state_n == SEND);
      eng_sel      <= (state_n == IDLE || state_n == FIN) ? 2'b00 : op_n;
      if (state_n == RD || state_n == WR) mem_addr <= addr_n;
      if (state_n == WR) mem_wdata <= result_n;
      if (state_n == SEND) eng_in_data <= operand_n;
    end
  end

endmodule

// File: tb/tb_accel_sequencer.sv
// Randomized bench for accel_sequencer: memory + engine models, transaction-level
// expected memory image, and per-cycle protocol monitoring.
module tb_accel_sequencer;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int NC = 10;
  localparam int C_BUSY = 0, C_RD = 1, C_WR = 2, C_DONE = 3, C_BOTH = 4,
                 C_SEL = 5, C_STAB = 6, C_XFER = 7, C_ADDR = 8, C_VHI = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic encr_en = 1'b0, decr_en = 1'b0, fft_en = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [7:0] length = '0;
  logic mem_rd, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [1:0] eng_sel;
  logic eng_in_valid;
  logic eng_in_ready = 1'b0;
  logic [DATA_W-1:0] eng_in_data;
  logic eng_out_valid = 1'b0;
  logic [DATA_W-1:0] eng_out_data = '0;
  logic busy, done;

  accel_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .encr_en(encr_en), .decr_en(decr_en), .fft_en(fft_en),
    .base_addr(base_addr), .length(length), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .eng_sel(eng_sel),
    .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready), .eng_in_data(eng_in_data),
    .eng_out_valid(eng_out_valid), .eng_out_data(eng_out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [46:0] outs;
  assign outs = {busy, done, mem_rd, mem_wr, eng_in_valid, eng_sel, mem_addr, mem_wdata, eng_in_data};

  logic [DATA_W-1:0] mem [256];
  int cnt [NC];
  int snap [NC];
  int cur_op = 0, exp_base = 0, ready_mode = 0, lat_min = 0, lat_max = 0;
  bit spur = 1'b0;
  int n_err = 0, n_checks = 0;

  function automatic logic [15:0] ref_fn(input int op, input logic [15:0] x);
    case (op)
      1:       return x ^ 16'hFFFF;
      2:       return x + 16'h1234;
      3:       return {x[7:0], x[15:8]};
      default: return 16'hDEAD;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Memory and engine models: sample at negedge, respond just after posedge
  initial begin
    logic s_rd, s_wr, s_hs, pend;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wd, s_data, pres;
    logic [1:0] s_sel;
    int wcnt, vcnt;
    pend = 1'b0; wcnt = 0; vcnt = 0; pres = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    forever begin
      @(negedge clk);
      s_rd = mem_rd; s_wr = mem_wr; s_addr = mem_addr; s_wd = mem_wdata;
      s_hs = eng_in_valid && eng_in_ready; s_data = eng_in_data; s_sel = eng_sel;
      if (s_hs) vcnt = 0;
      else if (eng_in_valid) vcnt++;
      @(posedge clk); #1;
      if (s_wr) mem[s_addr] = s_wd;
      mem_rdata = s_rd ? mem[s_addr] : 16'($urandom);
      if (s_hs) begin
        pend = 1'b1;
        pres = ref_fn(int'(s_sel), s_data);
        wcnt = $urandom_range(lat_max, lat_min);
      end
      eng_out_valid = 1'b0;
      if (pend) begin
        if (wcnt == 0) begin
          eng_out_valid = 1'b1;
          eng_out_data = pres;
          pend = 1'b0;
        end else wcnt--;
      end else if (spur) begin
        eng_out_valid = ($urandom_range(3, 0) == 0);
        eng_out_data = 16'($urandom);
      end
      case (ready_mode)
        0:       eng_in_ready = 1'b1;
        1:       eng_in_ready = 1'($urandom_range(1, 0));
        default: eng_in_ready = eng_in_valid && (vcnt >= 4);
      endcase
    end
  end

  // Per-cycle protocol monitor
  initial begin
    logic prev_v, prev_hs;
    logic [DATA_W-1:0] prev_d;
    int idx;
    prev_v = 1'b0; prev_hs = 1'b0; prev_d = '0;
    for (int i = 0; i < NC; i++) cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (busy) cnt[C_BUSY]++;
      if (done) cnt[C_DONE]++;
      if (mem_rd && mem_wr) cnt[C_BOTH]++;
      if (mem_rd) begin
        idx = cnt[C_RD] - snap[C_RD];
        if (mem_addr != ADDR_W'(exp_base + idx)) cnt[C_ADDR]++;
        cnt[C_RD]++;
      end
      if (mem_wr) begin
        idx = cnt[C_WR] - snap[C_WR];
        if (mem_addr != ADDR_W'(exp_base + idx)) cnt[C_ADDR]++;
        cnt[C_WR]++;
      end
      if (done || !busy) begin
        if (eng_sel != 2'b00) cnt[C_SEL]++;
      end else if (eng_sel != 2'(cur_op)) cnt[C_SEL]++;
      if (eng_in_valid) cnt[C_VHI]++;
      if (prev_v && !prev_hs && eng_in_valid && eng_in_data != prev_d) cnt[C_STAB]++;
      if (eng_in_valid && eng_in_ready) cnt[C_XFER]++;
      prev_v = eng_in_valid; prev_hs = eng_in_valid && eng_in_ready; prev_d = eng_in_data;
    end
  end

  task automatic run_op(input string name, input logic [2:0] req, input int base, input int len,
                        input int rmode, input int lmin, input int lmax, input bit noise);
    logic [DATA_W-1:0] exp_mem [256];
    int eop, bad;
    bit got;
    eop = req[0] ? 1 : (req[1] ? 2 : 3);
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
    for (int i = 0; i < len; i++) exp_mem[(base + i) % 256] = ref_fn(eop, exp_mem[(base + i) % 256]);
    cur_op = eop; exp_base = base; ready_mode = rmode; lat_min = lmin; lat_max = lmax; spur = noise;
    snap = cnt;
    @(posedge clk); #1;
    {fft_en, decr_en, encr_en} = req; base_addr = ADDR_W'(base); length = 8'(len);
    @(posedge clk); #1;
    {fft_en, decr_en, encr_en} = noise ? 3'($urandom) : 3'b000;
    base_addr = ADDR_W'($urandom); length = 8'($urandom);
    got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        @(posedge clk); #1;
        {fft_en, decr_en, encr_en} = noise ? 3'($urandom) : 3'b000;
      end
    end
    check({name, ":done_seen"}, 64'(got), 64'd1);
    @(posedge clk); #1;
    {fft_en, decr_en, encr_en} = 3'b000;
    @(negedge clk);
    check({name, ":idle_after"}, 64'(busy), 64'd0);
    check({name, ":reads"}, 64'(cnt[C_RD] - snap[C_RD]), 64'(len));
    check({name, ":writes"}, 64'(cnt[C_WR] - snap[C_WR]), 64'(len));
    check({name, ":done_pulses"}, 64'(cnt[C_DONE] - snap[C_DONE]), 64'd1);
    check({name, ":transfers"}, 64'(cnt[C_XFER] - snap[C_XFER]), 64'(len));
    check({name, ":rd_wr_overlap"}, 64'(cnt[C_BOTH] - snap[C_BOTH]), 64'd0);
    check({name, ":eng_sel"}, 64'(cnt[C_SEL] - snap[C_SEL]), 64'd0);
    check({name, ":operand_stable"}, 64'(cnt[C_STAB] - snap[C_STAB]), 64'd0);
    check({name, ":addr_seq"}, 64'(cnt[C_ADDR] - snap[C_ADDR]), 64'd0);
    if (rmode == 0 && lmax == 0)
      check({name, ":busy_cycles"}, 64'(cnt[C_BUSY] - snap[C_BUSY]), 64'(5 * len + 1));
    if (rmode == 2)
      check({name, ":valid_cycles"}, 64'(cnt[C_VHI] - snap[C_VHI]), 64'(5 * len));
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
    check({name, ":mem_image"}, 64'(bad), 64'd0);
  endtask

  initial begin
    bit got;
    logic [DATA_W-1:0] saved;
    for (int i = 0; i < NC; i++) snap[i] = 0;
    #1 rst_n = 1'b0;
    #2 check("reset_outputs", 64'(outs), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 64'({busy, done, mem_rd, mem_wr}), 64'd0);

    run_op("encr_len2",      3'b001, 8'h10, 2, 0, 0, 0, 1'b0);
    run_op("prio_fft_encr",  3'b101, 8'h22, 1, 0, 0, 0, 1'b0);
    run_op("decr_len0",      3'b010, 8'h30, 0, 0, 0, 0, 1'b0);
    run_op("ready_stall",    3'b100, 8'h50, 1, 2, 0, 0, 1'b0);
    run_op("addr_wrap",      3'b010, 8'hFF, 2, 0, 0, 0, 1'b0);
    run_op("prio_decr_fft",  3'b110, 8'h60, 3, 0, 0, 0, 1'b0);
    run_op("busy_ignore",    3'b100, 8'h70, 4, 1, 0, 2, 1'b1);
    for (int t = 0; t < 8; t++)
      run_op($sformatf("rand%0d", t), 3'($urandom_range(7, 1)), $urandom_range(255, 0),
             $urandom_range(6, 0), $urandom_range(1, 0), 0, $urandom_range(3, 0),
             1'($urandom_range(1, 0)));

    // Reset while the engine holds an operand; its late result must be dropped
    cur_op = 2; exp_base = 8'h40; ready_mode = 0; lat_min = 8; lat_max = 8; spur = 1'b0;
    snap = cnt; saved = mem[8'h40];
    @(posedge clk); #1;
    decr_en = 1'b1; base_addr = 8'h40; length = 8'd3;
    @(posedge clk); #1;
    decr_en = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = eng_in_valid && eng_in_ready;
    end
    check("rst_mid:transfer", 64'(got), 64'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("rst_mid:outputs", 64'(outs), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    snap = cnt;
    repeat (20) @(negedge clk);
    check("rst_mid:no_write", 64'(cnt[C_WR] - snap[C_WR]), 64'd0);
    check("rst_mid:no_busy", 64'(cnt[C_BUSY] - snap[C_BUSY]), 64'd0);
    check("rst_mid:mem_kept", 64'(mem[8'h40]), 64'(saved));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
